// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered execute stage between the ID/EX register and MEM.
//
// Purpose:
//   ALU and branch resolution with one valid/ready output register toward MEM,
//   a committed N/Z/V flag register, an iterative shift-add multiplier and a
//   synchronous pipeline flush. Redirects (pc_src/target) are resolved against
//   the flags committed before the instruction's own update.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               kill the held output and any in-flight multiply
//   in_valid/in_ready   handshake with ID/EX
//   pc, op, src0, src1, imm, use_imm, shamt, set_flags,
//   is_branch, br_cond, br_off, is_jal, is_jr   instruction fields
//   out_valid/out_ready handshake with MEM
//   result, target, pc_src   registered outputs
//   flags_q             committed {N,Z,V}
//
// Multiplier FSM:
//   state  | meaning
//   S_IDLE | no multiply in flight, stage may accept
//   S_BUSY | shift-add in progress, r_cnt steps completed
//   S_DONE | product ready, waiting for a free output slot

module ex_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int OFF_W  = 9,
  parameter int JOFF_W = 12,
  parameter int SH_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] src0,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic [SH_W-1:0]   shamt,
  input  logic              set_flags,
  input  logic              is_branch,
  input  logic [2:0]        br_cond,
  input  logic [OFF_W-1:0]  br_off,
  input  logic              is_jal,
  input  logic              is_jr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] target,
  output logic              pc_src,
  output logic [2:0]        flags_q
);

  localparam int MSB   = DATA_W - 1;
  localparam int SHC_W = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Output / committed state
  logic              r_out_valid;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] r_target;
  logic              r_pc_src;
  logic [2:0]        r_flags;

  // Multiplier state
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mul_setf;
  logic              r_mul_pc_src;
  logic [DATA_W-1:0] r_mul_target;

  // Combinational datapath
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [SHC_W-1:0]  w_sh;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_v;
  logic [DATA_W-1:0] w_pc_inc;
  logic [DATA_W-1:0] w_res;
  logic [2:0]        w_flags;
  logic [DATA_W-1:0] w_br_sext;
  logic [DATA_W-1:0] w_jal_sext;
  logic              w_cond;
  logic              w_pc_src;
  logic [DATA_W-1:0] w_target;

  logic              w_busy;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_mul_last;
  logic              w_mul_load;
  logic              w_alu_load;
  logic              w_load;
  logic [DATA_W-1:0] w_acc_step;
  logic [DATA_W-1:0] w_mul_prod;

  logic [DATA_W-1:0] w_ld_res;
  logic [DATA_W-1:0] w_ld_target;
  logic              w_ld_pc_src;
  logic              w_ld_setf;
  logic [2:0]        w_ld_flags;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign w_busy      = (r_state != S_IDLE);
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = !w_busy && w_slot_free && !flush;
  assign w_accept    = in_valid && in_ready;

  // JAL always completes in one cycle since its result is the link value.
  assign w_is_mul   = (op == OP_MUL) && !is_jal;
  assign w_mul_last = (r_state == S_BUSY) && (r_cnt == CNT_W'(DATA_W - 1));
  // A finished product leaves through the slot on the last BUSY edge or from
  // DONE; flush always wins over completion.
  assign w_mul_load = !flush && w_slot_free &&
                      (w_mul_last || (r_state == S_DONE));
  assign w_alu_load = w_accept && !w_is_mul;
  assign w_load     = w_alu_load || w_mul_load;

  // ---------------------------------------------------------------------------
  // Operands and ALU
  // ---------------------------------------------------------------------------
  assign w_a      = src0;
  assign w_b      = use_imm ? imm : src1;
  assign w_sh     = SHC_W'(32'(shamt) % DATA_W);
  assign w_sum    = w_a + w_b;
  assign w_diff   = w_a - w_b;
  assign w_pc_inc = pc + DATA_W'(1);

  always_comb begin
    w_alu_res = w_a;
    w_alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_v   = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_v   = (w_a[MSB] != w_b[MSB]) && (w_diff[MSB] != w_a[MSB]);
      end
      OP_AND:  w_alu_res = w_a & w_b;
      OP_OR:   w_alu_res = w_a | w_b;
      OP_XOR:  w_alu_res = w_a ^ w_b;
      OP_SLL:  w_alu_res = w_a << w_sh;
      OP_SRL:  w_alu_res = w_a >> w_sh;
      OP_SRA:  w_alu_res = $signed(w_a) >>> w_sh;
      default: w_alu_res = w_a;
    endcase
  end

  assign w_res   = is_jal ? w_pc_inc : w_alu_res;
  assign w_flags = {w_res[MSB], (w_res == '0), (w_alu_v && !is_jal)};

  // ---------------------------------------------------------------------------
  // Branch / jump resolution against committed flags
  // ---------------------------------------------------------------------------
  assign w_br_sext  = DATA_W'($signed(br_off));
  assign w_jal_sext = DATA_W'($signed(imm[JOFF_W-1:0]));

  always_comb begin
    w_cond = 1'b0;
    case (br_cond)
      3'd0:    w_cond = !r_flags[1];
      3'd1:    w_cond = r_flags[1];
      3'd2:    w_cond = !r_flags[1] && !r_flags[2];
      3'd3:    w_cond = r_flags[2];
      3'd4:    w_cond = !r_flags[2];
      3'd5:    w_cond = r_flags[2] || r_flags[1];
      3'd6:    w_cond = r_flags[0];
      default: w_cond = 1'b1;
    endcase
  end

  always_comb begin
    w_pc_src = 1'b0;
    w_target = w_pc_inc;
    if (is_jr) begin
      w_pc_src = 1'b1;
      w_target = w_a;
    end else if (is_jal) begin
      w_pc_src = 1'b1;
      w_target = pc + w_jal_sext + DATA_W'(1);
    end else if (is_branch && w_cond) begin
      w_pc_src = 1'b1;
      w_target = pc + w_br_sext + DATA_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (flush)           w_state_nxt = S_IDLE;
        else if (w_mul_last) w_state_nxt = w_mul_load ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (flush || w_mul_load) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One partial product per BUSY edge; the operands shift so only bit 0 of
  // the multiplier is ever inspected.
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_prod = (r_state == S_DONE) ? r_acc : w_acc_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_cnt        <= '0;
      r_mul_setf   <= 1'b0;
      r_mul_pc_src <= 1'b0;
      r_mul_target <= '0;
    end else if (w_accept && w_is_mul) begin
      r_acc        <= '0;
      r_mcand      <= w_a;
      r_mplier     <= w_b;
      r_cnt        <= '0;
      r_mul_setf   <= set_flags;
      r_mul_pc_src <= w_pc_src;
      r_mul_target <= w_target;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_comb begin
    if (w_mul_load) begin
      w_ld_res    = w_mul_prod;
      w_ld_target = r_mul_target;
      w_ld_pc_src = r_mul_pc_src;
      w_ld_setf   = r_mul_setf;
      w_ld_flags  = {w_mul_prod[MSB], (w_mul_prod == '0), 1'b0};
    end else begin
      w_ld_res    = w_res;
      w_ld_target = w_target;
      w_ld_pc_src = w_pc_src;
      w_ld_setf   = set_flags;
      w_ld_flags  = w_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_target    <= '0;
      r_pc_src    <= 1'b0;
      r_flags     <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_pc_src    <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_ld_res;
      r_target    <= w_ld_target;
      r_pc_src    <= w_ld_pc_src;
      if (w_ld_setf) r_flags <= w_ld_flags;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign target    = r_target;
  assign pc_src    = r_pc_src;
  assign flags_q   = r_flags;

endmodule
